// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
//   parcel_t       : one 16-bit instruction parcel
//   is_compressed  : a parcel whose low two bits are not 2'b11 starts a 16-bit instruction
//   INST_BYTES_C/W : byte length of a compressed / full-width instruction (and of a fetch word)
package fetch_pkg;
  typedef logic [15:0] parcel_t;

  localparam int INST_BYTES_C = 2;
  localparam int INST_BYTES_W = 4;

  function automatic logic is_compressed(parcel_t p);
    return p[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/parcel_fifo.sv
// Parcel queue between cache responses and the instruction aligner.
// Accepts 0/1/2 parcels and releases 0/1/2 parcels per cycle; flush empties it.
//   clk, rst         : clock, synchronous active-high reset
//   flush            : empty the queue this edge (overrides push and pop)
//   push_n, push_p0/1: number of parcels to write, in address order
//   pop_n            : number of parcels to retire from the head
//   head0, head1     : parcels at head and head+1 (head1 only meaningful when count >= 2)
//   count            : parcels held, 0..QDEPTH
module parcel_fifo
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 8,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [1:0]    push_n,
  input  parcel_t       push_p0,
  input  parcel_t       push_p1,
  input  logic [1:0]    pop_n,
  output parcel_t       head0,
  output parcel_t       head1,
  output logic [CW-1:0] count
);
  parcel_t        mem_q [QDEPTH];
  parcel_t        mem_d [QDEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_n != 2'd0) mem_d[wr_ptr_q] = push_p0;
      if (push_n == 2'd2) mem_d[wr_ptr_q + PW'(1)] = push_p1;
      wr_ptr_d = wr_ptr_q + PW'(push_n);
      rd_ptr_d = rd_ptr_q + PW'(pop_n);
      count_d  = count_q + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign head0 = mem_q[rd_ptr_q];
  assign head1 = mem_q[rd_ptr_q + PW'(1)];
  assign count = count_q;

  // The issue credit rule must keep every in-flight response from overflowing.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !flush |-> ({1'b0, count_q} + (CW+1)'(push_n) <= (CW+1)'(QDEPTH) + (CW+1)'(pop_n)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !flush |-> (CW'(pop_n) <= count_q));
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues word fetches with up to MAX_OUT in flight,
// queues returned parcels and realigns them into 16/32-bit instructions.
//   clk, rst                 : clock, synchronous active-high reset
//   stall                    : hold the current output instruction
//   trap_en/trap_pc          : trap redirect (wins over branch)
//   bj_en/bj_pc              : branch/jump redirect
//   req_valid/ready/addr     : word-aligned fetch request to the I-cache
//   rsp_valid/rsp_data       : in-order response words, never back-pressured
//   out_valid/inst_out/pc_out: aligned instruction to IF/ID
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h1000,
  parameter int              QDEPTH   = 8,
  parameter int              MAX_OUT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            bj_en,
  input  logic [XLEN-1:0] bj_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [31:0]     rsp_data,
  output logic            out_valid,
  output logic [31:0]     inst_out,
  output logic [XLEN-1:0] pc_out
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d, head_pc_q, head_pc_d;
  logic            skip_q, skip_d;
  logic [OW-1:0]   out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;

  logic            redirect, accept, need2, pop;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   fifo_cnt, free_parcels;
  parcel_t         p0, p1, push_p0, push_p1;
  logic [1:0]      push_n, pop_n;
  logic            flush;

  assign redirect = trap_en | bj_en;
  assign target   = trap_en ? trap_pc : bj_pc;

  // Reserve two parcels of space for every request in flight, including the new one.
  assign free_parcels = CW'(QDEPTH) - fifo_cnt;
  assign req_valid = !rst && (out_cnt_q < OW'(MAX_OUT))
                     && (int'(free_parcels) >= 2 * (int'(out_cnt_q) + 1));
  assign req_addr  = fetch_addr_q;
  assign accept    = req_valid & req_ready;

  assign need2     = !is_compressed(p0);
  assign out_valid = (fifo_cnt != '0) && (!need2 || fifo_cnt >= CW'(2));
  assign inst_out  = !out_valid ? 32'h0 : (need2 ? {p1, p0} : {16'h0, p0});
  assign pc_out    = head_pc_q;
  assign pop       = out_valid & !stall & !redirect;

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    head_pc_d    = head_pc_q;
    skip_d       = skip_q;
    drop_cnt_d   = drop_cnt_q;
    out_cnt_d    = out_cnt_q + OW'(accept) - OW'(rsp_valid);
    push_n       = 2'd0;
    push_p0      = rsp_data[15:0];
    push_p1      = rsp_data[31:16];
    pop_n        = 2'd0;
    flush        = 1'b0;
    if (accept) fetch_addr_d = fetch_addr_q + XLEN'(INST_BYTES_W);
    if (redirect) begin
      // Everything still in flight, including a request accepted right now, is stale.
      flush        = 1'b1;
      fetch_addr_d = target & ~XLEN'(3);
      head_pc_d    = target & ~XLEN'(1);
      skip_d       = target[1];
      drop_cnt_d   = out_cnt_d;
    end else begin
      if (pop) begin
        pop_n     = need2 ? 2'd2 : 2'd1;
        head_pc_d = head_pc_q + (need2 ? XLEN'(INST_BYTES_W) : XLEN'(INST_BYTES_C));
      end
      if (rsp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - OW'(1);
        end else if (skip_q) begin
          // Target was mid-word: only the upper parcel belongs to the new stream.
          push_n  = 2'd1;
          push_p0 = rsp_data[31:16];
          skip_d  = 1'b0;
        end else begin
          push_n = 2'd2;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr_q <= RESET_PC;
      head_pc_q    <= RESET_PC;
      skip_q       <= 1'b0;
      out_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
      skip_q       <= skip_d;
      out_cnt_q    <= out_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  parcel_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push_n  (push_n),
    .push_p0 (push_p0),
    .push_p1 (push_p1),
    .pop_n   (pop_n),
    .head0   (p0),
    .head1   (p1),
    .count   (fifo_cnt)
  );
endmodule
